// File: rtl/video_sync_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_sync_if                                                              |
// | Sync/DE stream in, delayed stream + coordinates + measured geometry out.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface video_sync_if #(
  parameter int CORDW = 10,
  parameter int CNTW  = 12
) ();
  logic             hsync;
  logic             vsync;
  logic             de;
  logic             hsync_o;
  logic             vsync_o;
  logic             de_o;
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic             frame_done;
  logic [CNTW-1:0]  h_total;
  logic [CNTW-1:0]  v_total;
  logic [CNTW-1:0]  h_active;
  logic [CNTW-1:0]  v_active;
  logic             meas_valid;
  logic             locked;
  logic             lock_err;

  modport master (
    output hsync, vsync, de,
    input  hsync_o, vsync_o, de_o, sx, sy, frame_done,
    input  h_total, v_total, h_active, v_active, meas_valid, locked, lock_err
  );

  modport slave (
    input  hsync, vsync, de,
    output hsync_o, vsync_o, de_o, sx, sy, frame_done,
    output h_total, v_total, h_active, v_active, meas_valid, locked, lock_err
  );
endinterface
`default_nettype wire

// File: rtl/video_sync_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_sync_decoder                                                         |
// | Recovers sx/sy from an hsync/vsync/de stream, measures geometry, locks.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module video_sync_decoder #(
  parameter int CORDW       = 10,
  parameter int CNTW        = 12,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2,
  parameter int H_TIMEOUT   = 4095
) (
  input  wire logic   clk_pix,
  input  wire logic   rst_n,
  video_sync_if.slave vid
);

  localparam logic [CNTW-1:0] c_CNT_MAX     = '1;
  localparam logic [3:0]      c_LOCK_FRAMES = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_TRACK    = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == c_CNT_MAX) ? v : v + CNTW'(1);
  endfunction

  logic             r_hs1, r_vs1, r_de1;
  logic             r_hs2, r_vs2, r_de2;
  logic             r_frame_done;
  logic             r_lock_err;
  logic             r_first_line;
  logic [CORDW-1:0] r_sx, r_sy;
  logic [CNTW-1:0]  r_hcnt, r_lcnt, r_acnt, r_arow;
  logic [CNTW-1:0]  r_h_meas, r_h_act_meas;
  logic [CNTW-1:0]  r_h_total, r_v_total, r_h_active, r_v_active;
  logic             r_seen_vs;
  logic             r_meas_valid;
  state_t           r_state;
  logic [3:0]       r_match_cnt;

  logic             w_hs_edge, w_vs_edge, w_de_rise;
  logic             w_timeout, w_publish, w_compare, w_match;
  state_t           w_state_nxt;
  logic [3:0]       w_match_nxt;
  logic             w_lock_err;

  assign w_hs_edge = (r_hs1 == SYNC_POL) && (r_hs2 != SYNC_POL);
  assign w_vs_edge = (r_vs1 == SYNC_POL) && (r_vs2 != SYNC_POL);
  assign w_de_rise = r_de1 && !r_de2;
  assign w_timeout = (int'(r_hcnt) == H_TIMEOUT);
  // The very first vs_edge after reset/timeout only opens a measurement window.
  assign w_publish = w_vs_edge && r_seen_vs && !w_timeout;
  assign w_compare = w_publish && r_meas_valid;
  assign w_match   = (r_h_meas == r_h_total) && (r_lcnt == r_v_total) &&
                     (r_h_act_meas == r_h_active) && (r_arow == r_v_active);

  // Stage 1 input register, previous-value register (doubles as output copy)
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_hs1        <= 1'b0;
      r_vs1        <= 1'b0;
      r_de1        <= 1'b0;
      r_hs2        <= 1'b0;
      r_vs2        <= 1'b0;
      r_de2        <= 1'b0;
      r_frame_done <= 1'b0;
      r_lock_err   <= 1'b0;
    end else begin
      r_hs1        <= vid.hsync;
      r_vs1        <= vid.vsync;
      r_de1        <= vid.de;
      r_hs2        <= r_hs1;
      r_vs2        <= r_vs1;
      r_de2        <= r_de1;
      r_frame_done <= w_vs_edge;
      r_lock_err   <= w_lock_err;
    end
  end

  // Coordinates; a vs_edge coinciding with de_rise arms first_line for the next row
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_sx         <= '0;
      r_sy         <= '0;
      r_first_line <= 1'b0;
    end else begin
      if (w_de_rise) begin
        r_sx <= '0;
      end else if (r_de1) begin
        r_sx <= r_sx + CORDW'(1);
      end

      if (w_de_rise) begin
        r_sy <= r_first_line ? '0 : r_sy + CORDW'(1);
      end

      if (w_vs_edge) begin
        r_first_line <= 1'b1;
      end else if (w_de_rise) begin
        r_first_line <= 1'b0;
      end
    end
  end

  // Running counters
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt       <= '0;
      r_lcnt       <= '0;
      r_acnt       <= '0;
      r_arow       <= '0;
      r_h_meas     <= '0;
      r_h_act_meas <= '0;
    end else begin
      r_hcnt <= w_hs_edge ? CNTW'(1) : sat_inc(r_hcnt);

      // A coincident hs_edge belongs to the frame that is just starting
      if (w_vs_edge) begin
        r_lcnt <= w_hs_edge ? CNTW'(1) : '0;
      end else if (w_hs_edge) begin
        r_lcnt <= sat_inc(r_lcnt);
      end

      if (w_de_rise) begin
        r_acnt <= CNTW'(1);
      end else if (r_de1) begin
        r_acnt <= sat_inc(r_acnt);
      end

      if (w_vs_edge) begin
        r_arow <= w_de_rise ? CNTW'(1) : '0;
      end else if (w_de_rise) begin
        r_arow <= sat_inc(r_arow);
      end

      if (w_hs_edge) begin
        r_h_meas     <= r_hcnt;
        r_h_act_meas <= r_acnt;
      end
    end
  end

  // Published measurements and history
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_h_total    <= '0;
      r_v_total    <= '0;
      r_h_active   <= '0;
      r_v_active   <= '0;
      r_seen_vs    <= 1'b0;
      r_meas_valid <= 1'b0;
    end else begin
      if (w_publish) begin
        r_h_total  <= r_h_meas;
        r_v_total  <= r_lcnt;
        r_h_active <= r_h_act_meas;
        r_v_active <= r_arow;
      end

      if (w_timeout) begin
        r_seen_vs    <= 1'b0;
        r_meas_valid <= 1'b0;
      end else begin
        if (w_vs_edge) r_seen_vs    <= 1'b1;
        if (w_publish) r_meas_valid <= 1'b1;
      end
    end
  end

  // Lock FSM
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_UNLOCKED;
      r_match_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_match_cnt <= w_match_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match_cnt;
    w_lock_err  = 1'b0;
    if (w_timeout) begin
      w_state_nxt = ST_UNLOCKED;
      w_match_nxt = '0;
      w_lock_err  = (r_state == ST_LOCKED);
    end else if (w_compare) begin
      case (r_state)
        ST_UNLOCKED: begin
          if (w_match) begin
            w_match_nxt = 4'd1;
            w_state_nxt = (c_LOCK_FRAMES <= 4'd1) ? ST_LOCKED : ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (w_match) begin
            w_match_nxt = r_match_cnt + 4'd1;
            if ((r_match_cnt + 4'd1) >= c_LOCK_FRAMES) begin
              w_state_nxt = ST_LOCKED;
            end
          end else begin
            w_state_nxt = ST_UNLOCKED;
            w_match_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (!w_match) begin
            w_state_nxt = ST_UNLOCKED;
            w_match_nxt = '0;
            w_lock_err  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_UNLOCKED;
          w_match_nxt = '0;
        end
      endcase
    end
  end

  assign vid.hsync_o    = r_hs2;
  assign vid.vsync_o    = r_vs2;
  assign vid.de_o       = r_de2;
  assign vid.sx         = r_sx;
  assign vid.sy         = r_sy;
  assign vid.frame_done = r_frame_done;
  assign vid.h_total    = r_h_total;
  assign vid.v_total    = r_v_total;
  assign vid.h_active   = r_h_active;
  assign vid.v_active   = r_v_active;
  assign vid.meas_valid = r_meas_valid;
  assign vid.locked     = (r_state == ST_LOCKED);
  assign vid.lock_err   = r_lock_err;

endmodule
`default_nettype wire
